// File: rtl/planificador_rr_pkg.sv
// planificador_rr_pkg: shared FSM encoding, default geometry and destination field layout.
package planificador_rr_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SERVE = 1'b1} state_t;
  localparam int WORD_SIZE_DEF = 10;
  localparam int BURST_DEF = 4;
  localparam int CNT_WIDTH_DEF = 8;
  // destination sits in the top DEST_W bits of every word
  localparam int DEST_W = 2;
endpackage

// File: rtl/planificador_rr_if.sv
// planificador_rr_if: ingress FIFO heads, egress FIFO strobes/data and status of the scheduler.
interface planificador_rr_if #(parameter int WORD_SIZE = 10, parameter int CNT_WIDTH = 8);
  logic [3:0] empty_p;
  logic [3:0] almostfull_p;
  logic [3:0] pop_p;
  logic [3:0] push_p;
  logic [WORD_SIZE-1:0] data_in [4];
  logic [WORD_SIZE-1:0] data_out [4];
  logic [CNT_WIDTH-1:0] cnt_out [4];
  logic idle;
  modport master(output empty_p, almostfull_p, data_in, input pop_p, push_p, data_out, cnt_out, idle);
  modport slave(input empty_p, almostfull_p, data_in, output pop_p, push_p, data_out, cnt_out, idle);
endinterface

// File: rtl/planificador_rr_selector_rr.sv
// planificador_rr_selector_rr: rotating-priority picker, first request at or after ptr.
module planificador_rr_selector_rr (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       found
);
  logic [3:0] rot;
  always_comb begin
    rot = 4'({req, req} >> ptr);
    found = |rot;
    idx = ptr + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
  end
endmodule

// File: rtl/planificador_rr.sv
// planificador_rr: round-robin mover from four ingress FIFOs to four egress FIFOs with
// bounded bursts, almostfull release and per-output saturating counters.
module planificador_rr
  import planificador_rr_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int BURST = BURST_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input logic clk,
  input logic reset,
  planificador_rr_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;
  state_t state;
  logic [1:0] ptr, gnt, idx, dest;
  logic [3:0] bcnt;
  logic found, serve, pop_ok, leave;
  planificador_rr_selector_rr u_sel (.req(~bus.empty_p), .ptr(ptr), .idx(idx), .found(found));
  always_comb begin
    serve = state == ST_SERVE;
    dest = bus.data_in[gnt][WORD_SIZE-1 -: DEST_W];
    pop_ok = serve && !bus.empty_p[gnt] && !bus.almostfull_p[dest];
    // a stalled grant is released instead of held, so other inputs keep flowing
    leave = !pop_ok || bcnt == 4'(BURST - 1);
    bus.pop_p = pop_ok ? 4'b1 << gnt : 4'b0;
    bus.idle = !serve && bus.push_p == 4'b0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr <= '0;
      gnt <= '0;
      bcnt <= '0;
      bus.push_p <= '0;
      for (int i = 0; i < 4; i++) begin
        bus.data_out[i] <= '0;
        bus.cnt_out[i] <= '0;
      end
    end else begin
      bus.push_p <= pop_ok ? 4'b1 << dest : 4'b0;
      if (pop_ok) begin
        bus.data_out[dest] <= bus.data_in[gnt];
        if (bus.cnt_out[dest] != CMAX) bus.cnt_out[dest] <= bus.cnt_out[dest] + 1'b1;
      end
      if (!serve) begin
        if (found) begin
          state <= ST_SERVE;
          gnt <= idx;
          bcnt <= '0;
        end
      end else begin
        if (pop_ok) bcnt <= bcnt + 1'b1;
        if (leave) begin
          state <= ST_IDLE;
          ptr <= gnt + 2'd1;
        end
      end
    end
  end
endmodule
